// File: rtl/spr16x2_fifo_pkg.sv
// Shared widths, op encoding and pointer helper for the SPR16X2-backed FIFO controller.
// Pure declarations: no latency and no flow control of its own.
package spr16x2_fifo_pkg;

    localparam int AW    = 4;
    localparam int DW    = 2;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WR,
        OP_RD,
        OP_BYP
    } op_e;

    // Pointers wrap at depth-1 rather than at the natural power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p, input int depth);
        return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
    endfunction

endpackage

// File: rtl/spr16x2_port_arb.sv
// Picks the single RAM port operation for this cycle; conflicts alternate via lastg.
// Combinational, zero latency; a losing write simply leaves the push un-ready.
module spr16x2_port_arb
    import spr16x2_fifo_pkg::*;
(
    input  logic need_fetch,
    input  logic wr_req,
    input  logic byp,
    input  logic lastg,
    output op_e  op,
    output logic lastg_nxt
);

    logic conflict;

    assign conflict = need_fetch & wr_req;

    always_comb begin
        op        = OP_IDLE;
        lastg_nxt = lastg;
        if (byp) begin
            op = OP_BYP;
        end else if (conflict) begin
            // lastg = 1 means the write won last time, so the read goes now.
            op        = lastg ? OP_RD : OP_WR;
            lastg_nxt = ~lastg;
        end else if (need_fetch) begin
            op = OP_RD;
        end else if (wr_req) begin
            op = OP_WR;
        end
    end

endmodule

// File: rtl/spr16x2_fifo_ctl.sv
// FIFO over one single-port SPR16X2 RAM with a registered show-ahead head stage.
// Latency 1 edge via bypass, 2 via RAM; IN_READY drops when the RAM is full or loses the port.
module spr16x2_fifo_ctl
    import spr16x2_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic             CK,
    input  logic             SRN,
    input  logic             IN_VALID,
    input  logic [DW-1:0]    IN_DATA,
    output logic             IN_READY,
    output logic             OUT_VALID,
    output logic [DW-1:0]    OUT_DATA,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] COUNT,
    output logic             ALMOST_FULL,
    output logic [AW-1:0]    RAM_AD,
    output logic [DW-1:0]    RAM_DI,
    output logic             RAM_WRE,
    output logic             RAM_WPE,
    input  logic [DW-1:0]    RAM_DO
);

    logic [AW-1:0]    wptr, wptr_nxt;
    logic [AW-1:0]    rptr, rptr_nxt;
    logic [CNT_W-1:0] ram_cnt, ram_cnt_nxt, cnt_nxt;
    logic             oreg_v, oreg_v_nxt;
    logic [DW-1:0]    oreg_d, oreg_d_nxt;
    logic             lastg, lastg_nxt;
    logic             af_q;
    logic             pop, head_free, ram_empty, ram_full;
    logic             need_fetch, byp, wr_req;
    op_e              op;

    assign pop        = oreg_v & OUT_READY;
    assign head_free  = ~oreg_v | pop;
    assign ram_empty  = (ram_cnt == '0);
    assign ram_full   = (ram_cnt >= CNT_W'(DEPTH));
    assign need_fetch = head_free & ~ram_empty;
    assign byp        = IN_VALID & ram_empty & head_free;
    assign wr_req     = IN_VALID & ~ram_full & ~byp;

    spr16x2_port_arb u_arb (
        .need_fetch (need_fetch),
        .wr_req     (wr_req),
        .byp        (byp),
        .lastg      (lastg),
        .op         (op),
        .lastg_nxt  (lastg_nxt)
    );

    always_comb begin
        wptr_nxt    = wptr;
        rptr_nxt    = rptr;
        ram_cnt_nxt = ram_cnt;
        oreg_v_nxt  = oreg_v;
        oreg_d_nxt  = oreg_d;
        unique case (op)
            OP_BYP: begin
                oreg_d_nxt = IN_DATA;
                oreg_v_nxt = 1'b1;
            end
            OP_RD: begin
                oreg_d_nxt  = RAM_DO;
                oreg_v_nxt  = 1'b1;
                rptr_nxt    = ptr_inc(rptr, DEPTH);
                ram_cnt_nxt = ram_cnt - CNT_W'(1);
            end
            OP_WR: begin
                wptr_nxt    = ptr_inc(wptr, DEPTH);
                ram_cnt_nxt = ram_cnt + CNT_W'(1);
                if (pop) oreg_v_nxt = 1'b0;
            end
            default: begin
                if (pop) oreg_v_nxt = 1'b0;
            end
        endcase
    end

    assign cnt_nxt = ram_cnt_nxt + CNT_W'(oreg_v_nxt);

    always_ff @(posedge CK) begin
        if (!SRN) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            oreg_v  <= 1'b0;
            oreg_d  <= '0;
            lastg   <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            ram_cnt <= ram_cnt_nxt;
            oreg_v  <= oreg_v_nxt;
            oreg_d  <= oreg_d_nxt;
            lastg   <= lastg_nxt;
            af_q    <= (cnt_nxt >= CNT_W'(AFULL_LVL));
        end
    end

    assign IN_READY    = SRN & ((op == OP_WR) | (op == OP_BYP));
    assign OUT_VALID   = oreg_v;
    assign OUT_DATA    = oreg_d;
    assign COUNT       = ram_cnt + CNT_W'(oreg_v);
    assign ALMOST_FULL = af_q;
    assign RAM_AD      = (op == OP_WR) ? wptr : rptr;
    assign RAM_DI      = IN_DATA;
    assign RAM_WRE     = SRN & (op == OP_WR);
    assign RAM_WPE     = SRN;

endmodule

// File: tb/tb_spr16x2_fifo_ctl.sv
// Bench for spr16x2_fifo_ctl: instance 0 at DEPTH 16, instance 1 at DEPTH 5 for pointer wrap.
// Each instance drives a behavioural SPR16X2 RAM model and is compared to a list-based FIFO model.
module tb_spr16x2_fifo_ctl;

    logic       ck = 1'b0;
    always #5 ck = ~ck;

    logic       srn [2];
    logic       iv  [2];
    logic       ordy[2];
    logic [1:0] id  [2];
    logic       ir  [2];
    logic       ovo [2];
    logic [1:0] od  [2];
    logic [4:0] cnt [2];
    logic       af  [2];
    logic [3:0] ad  [2];
    logic [1:0] di  [2];
    logic       wre [2];
    logic       wpe [2];
    logic [1:0] rdo [2];

    spr16x2_fifo_ctl #(.DEPTH(16), .AFULL_LVL(12)) u_dut0 (
        .CK(ck), .SRN(srn[0]), .IN_VALID(iv[0]), .IN_DATA(id[0]), .IN_READY(ir[0]),
        .OUT_VALID(ovo[0]), .OUT_DATA(od[0]), .OUT_READY(ordy[0]), .COUNT(cnt[0]),
        .ALMOST_FULL(af[0]), .RAM_AD(ad[0]), .RAM_DI(di[0]), .RAM_WRE(wre[0]),
        .RAM_WPE(wpe[0]), .RAM_DO(rdo[0])
    );

    spr16x2_fifo_ctl #(.DEPTH(5), .AFULL_LVL(4)) u_dut1 (
        .CK(ck), .SRN(srn[1]), .IN_VALID(iv[1]), .IN_DATA(id[1]), .IN_READY(ir[1]),
        .OUT_VALID(ovo[1]), .OUT_DATA(od[1]), .OUT_READY(ordy[1]), .COUNT(cnt[1]),
        .ALMOST_FULL(af[1]), .RAM_AD(ad[1]), .RAM_DI(di[1]), .RAM_WRE(wre[1]),
        .RAM_WPE(wpe[1]), .RAM_DO(rdo[1])
    );

    // SPR16X2: address/data/enable latched at the rising edge, array written at the falling edge.
    logic [1:0] mem [2][16];
    logic [3:0] lad [2];
    logic [1:0] ldi [2];
    logic       lwe [2];

    always @(posedge ck) begin
        for (int k = 0; k < 2; k++) begin
            lad[k] <= ad[k];
            ldi[k] <= di[k];
            lwe[k] <= wre[k] & wpe[k];
        end
    end

    always @(negedge ck) begin
        for (int k = 0; k < 2; k++)
            if (lwe[k]) mem[k][lad[k]] <= ldi[k];
    end

    assign rdo[0] = mem[0][ad[0]];
    assign rdo[1] = mem[1][ad[1]];

    // Model: whole FIFO as one ordered list; mov says whether its head sits in the output register.
    logic [1:0] md [2][64];
    int         hd [2];
    int         n  [2];
    int         wn [2];
    int         rn [2];
    bit         mov[2];
    bit         lg [2];
    bit         acc[2];

    int checks   = 0;
    int failures = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 16 : 5;
    endfunction

    function automatic int afl(input int k);
        return (k == 0) ? 12 : 4;
    endfunction

    function automatic logic [1:0] pat(input int p);
        logic [1:0] v;
        v = 2'((p * 3 + 1) % 4);
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic decide(input int k, output bit pop, output bit byp, output bit need,
                          output bit wr, output bit rd, output bit conf);
        int  rc;
        bit  fr, wreq;
        rc   = n[k] - (mov[k] ? 1 : 0);
        pop  = mov[k] && ordy[k];
        fr   = !mov[k] || pop;
        need = fr && (rc != 0);
        byp  = iv[k] && (rc == 0) && fr;
        wreq = iv[k] && (rc < dep(k)) && !byp;
        conf = need && wreq;
        wr   = wreq && (!need || !lg[k]);
        rd   = need && (!wreq || lg[k]);
    endtask

    task automatic check_cycle();
        bit pop, byp, need, wr, rd, conf;
        for (int k = 0; k < 2; k++) begin
            decide(k, pop, byp, need, wr, rd, conf);
            chk("in_ready", k, int'(ir[k]), int'(srn[k] && (byp || wr)));
            chk("ram_wre", k, int'(wre[k]), int'(srn[k] && wr));
            chk("ram_wpe", k, int'(wpe[k]), int'(srn[k]));
            chk("out_valid", k, int'(ovo[k]), int'(mov[k]));
            chk("count", k, int'(cnt[k]), n[k]);
            chk("almost_full", k, int'(af[k]), int'(n[k] >= afl(k)));
            if (mov[k]) chk("out_data", k, int'(od[k]), int'(md[k][hd[k] % 64]));
            if (srn[k]) chk("ram_ad", k, int'(ad[k]), wr ? (wn[k] % dep(k)) : (rn[k] % dep(k)));
            if (srn[k] && wr) chk("ram_di", k, int'(di[k]), int'(id[k]));
        end
    endtask

    task automatic model_step();
        bit pop, byp, need, wr, rd, conf;
        for (int k = 0; k < 2; k++) begin
            decide(k, pop, byp, need, wr, rd, conf);
            if (!srn[k]) begin
                hd[k] = 0; n[k] = 0; wn[k] = 0; rn[k] = 0;
                mov[k] = 1'b0; lg[k] = 1'b0; acc[k] = 1'b0;
            end else begin
                if (pop) begin
                    hd[k] = (hd[k] + 1) % 64;
                    n[k]  = n[k] - 1;
                end
                if (byp || wr) begin
                    md[k][(hd[k] + n[k]) % 64] = id[k];
                    n[k] = n[k] + 1;
                end
                mov[k] = (byp || rd) ? 1'b1 : (pop ? 1'b0 : mov[k]);
                if (conf) lg[k] = !lg[k];
                if (wr) wn[k] = wn[k] + 1;
                if (rd) rn[k] = rn[k] + 1;
                acc[k] = byp || wr;
            end
        end
    endtask

    task automatic tick();
        @(negedge ck);
        check_cycle();
        @(posedge ck);
        model_step();
        #1;
    endtask

    initial begin
        int p, e, guard;
        for (int k = 0; k < 2; k++) begin
            srn[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; id[k] = 2'b00;
            hd[k] = 0; n[k] = 0; wn[k] = 0; rn[k] = 0;
            mov[k] = 1'b0; lg[k] = 1'b0; acc[k] = 1'b0;
        end
        iv[0] = 1'b1; id[0] = 2'b11;
        @(posedge ck); #1;

        // Reset held while pushing
        tick(); tick();
        chk("rst_count", 0, int'(cnt[0]), 0);
        chk("rst_out_valid", 0, int'(ovo[0]), 0);
        chk("rst_ram_wre", 0, int'(wre[0]), 0);
        chk("rst_in_ready", 0, int'(ir[0]), 0);

        // Bypass into an empty FIFO
        srn[0] = 1'b1; srn[1] = 1'b1; id[0] = 2'b10; #1;
        chk("byp_in_ready", 0, int'(ir[0]), 1);
        chk("byp_ram_wre", 0, int'(wre[0]), 0);
        tick();
        iv[0] = 1'b0;
        chk("byp_out_valid", 0, int'(ovo[0]), 1);
        chk("byp_out_data", 0, int'(od[0]), 2);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("byp_drained", 0, int'(cnt[0]), 0);

        // Fill to DEPTH+1 with no pops
        iv[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            id[0] = 2'(i % 4);
            tick();
        end
        id[0] = 2'b01; #1;
        chk("fill_count", 0, int'(cnt[0]), 17);
        chk("fill_afull", 0, int'(af[0]), 1);
        chk("fill_18th_ready", 0, int'(ir[0]), 0);
        ordy[0] = 1'b1; #1;
        chk("full_pop_ready", 0, int'(ir[0]), 0);
        iv[0] = 1'b0;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("drain_order", 0, int'(od[0]), i % 4);
            tick();
        end
        ordy[0] = 1'b0;
        chk("drain_count", 0, int'(cnt[0]), 0);

        // Conflict: fresh reset, build OREG + 3 in RAM, then push and pop every cycle
        srn[0] = 1'b0; tick(); srn[0] = 1'b1;
        p = 0; guard = 0;
        iv[0] = 1'b1;
        while (p < 4 && guard < 20) begin
            id[0] = pat(p);
            tick();
            if (acc[0]) p++;
            guard++;
        end
        chk("conf_setup_count", 0, int'(cnt[0]), 4);
        ordy[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            id[0] = pat(p); #1;
            chk("conf_grant_wr", 0, int'(wre[0]), int'(j % 2 == 0));
            tick();
            if (acc[0]) p++;
        end
        iv[0] = 1'b0;
        for (int j = 0; j < 20; j++) tick();
        ordy[0] = 1'b0;
        chk("conf_drained", 0, int'(cnt[0]), 0);

        // Wrap on the DEPTH=5 instance
        p = 0; e = 0; guard = 0;
        iv[1] = 1'b1;
        while (p < 4 && guard < 20) begin
            id[1] = pat(p);
            tick();
            if (acc[1]) p++;
            guard++;
        end
        ordy[1] = 1'b1;
        guard = 0;
        while (p < 12 && guard < 100) begin
            id[1] = pat(p); #1;
            if (ovo[1]) begin
                chk("wrap_order", 1, int'(od[1]), int'(pat(e)));
                e++;
            end
            tick();
            if (acc[1]) p++;
            guard++;
        end
        chk("wrap_pushed", 1, p, 12);
        iv[1] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            #1;
            if (ovo[1]) begin
                chk("wrap_order", 1, int'(od[1]), int'(pat(e)));
                e++;
            end
            tick();
        end
        chk("wrap_popped", 1, e, 12);
        chk("wrap_count", 1, int'(cnt[1]), 0);
        ordy[1] = 1'b0;

        // Reset in the middle of traffic
        iv[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            id[0] = pat(i);
            tick();
        end
        chk("mid_count", 0, int'(cnt[0]), 9);
        srn[0] = 1'b0;
        tick();
        chk("mid_rst_count", 0, int'(cnt[0]), 0);
        chk("mid_rst_valid", 0, int'(ovo[0]), 0);
        srn[0] = 1'b1; id[0] = 2'b01;
        tick();
        iv[0] = 1'b0;
        chk("mid_byp_valid", 0, int'(ovo[0]), 1);
        chk("mid_byp_data", 0, int'(od[0]), 1);
        chk("mid_byp_count", 0, int'(cnt[0]), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
